input_stream_mux: RTL and testbench

//   Parametrised N-source frame-aware input selector feeding the CNN datapath with Q8.8 pixels.

---
 rtl/input_stream_mux.sv | 175 +++++++++++++++++
 tb/tb_input_stream_mux.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_stream_mux.sv
// input_stream_mux
//   Frame-aware N-source selector for the CNN pixel datapath (Q8.8 pixels).
//   The source changes only between frames. The output is one registered
//   stage. Pixels and completed frames are counted for the controller.
//   Optional build macro: FRAME_CHECK_EN adds a frame-length check that
//   drives frame_err. When the macro is undefined, frame_err is tied to 0.
module input_stream_mux #(
   parameter int N         = 16,
   parameter int NUM_SRC   = 4,
   parameter int SELW      = 2,
   parameter int FRAME_PIX = 784,
   parameter int CNTW      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SELW-1:0]           sel_req,
   input  logic [NUM_SRC-1:0]        in_valid,
   input  logic [NUM_SRC-1:0]        in_last,
   input  logic [NUM_SRC*N-1:0]      in_data,
   output logic [NUM_SRC-1:0]        in_ready,
   output logic                      out_valid,
   output logic                      out_last,
   output logic signed [N-1:0]       out_data,
   input  logic                      out_ready,
   output logic [SELW-1:0]           active_sel,
   output logic                      busy,
   output logic                      sel_err,
   output logic [CNTW-1:0]           pix_cnt,
   output logic [CNTW-1:0]           frame_cnt,
   output logic                      frame_err
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   // One extra bit so that "sel_req >= NUM_SRC" is also meaningful when NUM_SRC == 2**SELW.
   localparam logic [SELW:0] SRC_LIM = (SELW+1)'(NUM_SRC);

   state_t              r_state;
   state_t              w_state_next;
   logic [SELW-1:0]     r_active_sel;
   logic                r_sel_err;
   logic                r_out_valid;
   logic                r_out_last;
   logic [N-1:0]        r_out_data;
   logic [CNTW-1:0]     r_pix_cnt;
   logic [CNTW-1:0]     r_frame_cnt;

   logic                w_req_ok;
   logic                w_sel_load;
   logic                w_sel_bad;
   logic                w_take_en;
   logic                w_acc;
   logic                w_sel_valid;
   logic                w_sel_last;
   logic [N-1:0]        w_sel_data;
   logic [N-1:0]        w_src_data [NUM_SRC];

   assign w_req_ok = ({1'b0, sel_req} < SRC_LIM);

   // The output slot is free when it is empty or is being drained this cycle.
   assign w_take_en = (r_state == S_STREAM) && (!r_out_valid || out_ready);

   // Unpack the flattened source buses. Ready goes only to the latched source.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_src_data[gi] = in_data[gi*N +: N];
      assign in_ready[gi]   = w_take_en && (r_active_sel == SELW'(gi));
   end

   assign w_sel_valid = in_valid[r_active_sel];
   assign w_sel_last  = in_last[r_active_sel];
   assign w_sel_data  = w_src_data[r_active_sel];
   assign w_acc       = w_take_en && w_sel_valid;

   // Next state: start a frame on a legal request, end it on an accepted last beat.
   always_comb begin
      w_state_next = r_state;
      w_sel_load   = 1'b0;
      w_sel_bad    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req_ok) begin
               w_state_next = S_STREAM;
               w_sel_load   = 1'b1;
            end else begin
               w_sel_bad    = 1'b1;
            end
         end
         S_STREAM: begin
            if (w_acc && w_sel_last) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register, latched source, and the illegal-select pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_active_sel <= '0;
         r_sel_err    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_sel_err <= w_sel_bad;
         if (w_sel_load) begin
            r_active_sel <= sel_req;
         end
      end
   end

   // Output stage: capture on accept, and hold while the downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else if (w_acc) begin
         r_out_valid <= 1'b1;
         r_out_last  <= w_sel_last;
         r_out_data  <= w_sel_data;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Counters: the pixel count saturates, and the frame count wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix_cnt   <= '0;
         r_frame_cnt <= '0;
      end else if (w_acc) begin
         if (w_sel_last) begin
            r_pix_cnt   <= '0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end else if (r_pix_cnt != '1) begin
            r_pix_cnt   <= r_pix_cnt + 1'b1;
         end
      end
   end

`ifdef FRAME_CHECK_EN
   localparam logic [CNTW-1:0] PIX_LAST = CNTW'(FRAME_PIX - 1);

   logic r_frame_err;

   // Flag a last beat at the wrong position. Also flag, once per frame, the
   // beat that carries the count past FRAME_PIX without a last.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_acc && (( w_sel_last && (r_pix_cnt != PIX_LAST)) ||
                                  (!w_sel_last && (r_pix_cnt == PIX_LAST)));
      end
   end

   assign frame_err = r_frame_err;
`else
   assign frame_err = 1'b0;
`endif

   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign out_data   = r_out_data;
   assign active_sel = r_active_sel;
   assign busy       = (r_state == S_STREAM);
   assign sel_err    = r_sel_err;
   assign pix_cnt    = r_pix_cnt;
   assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_input_stream_mux.sv
// Directed bench for input_stream_mux. A 4-source instance runs the frame
// scenarios. A 3-source instance exercises the illegal-select pulse.
// FRAME_CHECK_EN, when defined for the build, also enables the frame-length
// expectations.
module tb_input_stream_mux;

`ifdef FRAME_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [1:0]  sel_req;
   logic [3:0]  in_valid;
   logic [3:0]  in_last;
   logic [63:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic        out_last;
   logic [15:0] out_data;
   logic        out_ready;
   logic [1:0]  active_sel;
   logic        busy;
   logic        sel_err;
   logic [15:0] pix_cnt;
   logic [15:0] frame_cnt;
   logic        frame_err;

   logic [1:0]  sel_req3;
   logic [2:0]  in_ready3;
   logic        out_valid3;
   logic        out_last3;
   logic [15:0] out_data3;
   logic [1:0]  active_sel3;
   logic        busy3;
   logic        sel_err3;
   logic [15:0] pix_cnt3;
   logic [15:0] frame_cnt3;
   logic        frame_err3;

   int n_cmp = 0;
   int n_err = 0;
   int exp_pix;
   int exp_frames;

   input_stream_mux #(.N(16), .NUM_SRC(4), .SELW(2), .FRAME_PIX(4), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .sel_req(sel_req), .in_valid(in_valid), .in_last(in_last),
      .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last),
      .out_data(out_data), .out_ready(out_ready), .active_sel(active_sel), .busy(busy),
      .sel_err(sel_err), .pix_cnt(pix_cnt), .frame_cnt(frame_cnt), .frame_err(frame_err)
   );

   input_stream_mux #(.N(16), .NUM_SRC(3), .SELW(2), .FRAME_PIX(4), .CNTW(16)) dut3 (
      .clk(clk), .rst(rst), .sel_req(sel_req3), .in_valid(3'b000), .in_last(3'b000),
      .in_data(48'h0), .in_ready(in_ready3), .out_valid(out_valid3), .out_last(out_last3),
      .out_data(out_data3), .out_ready(1'b1), .active_sel(active_sel3), .busy(busy3),
      .sel_err(sel_err3), .pix_cnt(pix_cnt3), .frame_cnt(frame_cnt3), .frame_err(frame_err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One frame on source src: an idle/start cycle, then n beats carrying data base+b.
   task automatic send(input int src, input int n, input bit has_last, input int err_beat,
                       input logic [15:0] base, input string tag);
      in_valid = '0;
      in_last  = '0;
      step();
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_sel"}, active_sel, src);
      for (int b = 1; b <= n; b++) begin
         in_valid = 4'(1 << src);
         in_last  = (has_last && b == n) ? 4'(1 << src) : 4'b0000;
         in_data  = '0;
         in_data[src*16 +: 16] = base + 16'(b);
         step();
         if (has_last && b == n) begin
            exp_pix = 0;
            exp_frames++;
         end else begin
            exp_pix++;
         end
         chk({tag, "_ov"}, out_valid, 1);
         chk({tag, "_od"}, out_data, base + 16'(b));
         chk({tag, "_pix"}, pix_cnt, exp_pix);
         chk({tag, "_ferr"}, frame_err, (CHK && b == err_beat) ? 1 : 0);
         $display("%s beat %0d: data=%h pix=%0d frames=%0d frame_err=%b",
                  tag, b, out_data, pix_cnt, frame_cnt, frame_err);
      end
      chk({tag, "_frames"}, frame_cnt, exp_frames);
      in_valid = '0;
      in_last  = '0;
   endtask

   initial begin
      logic [15:0] d2;
      rst = 1'b1; sel_req = 2'd0; sel_req3 = 2'd3;
      in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
      step();
      step();
      chk("rst_ov", out_valid, 0);
      chk("rst_ol", out_last, 0);
      chk("rst_od", out_data, 0);
      chk("rst_rdy", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pix", pix_cnt, 0);
      chk("rst_frm", frame_cnt, 0);
      chk("rst_sel", active_sel, 0);
      chk("rst_selerr", sel_err, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_selerr3", sel_err3, 0);
      $display("reset: out_valid=%b busy=%b pix=%0d frames=%0d", out_valid, busy, pix_cnt, frame_cnt);

      // Test 1: source 2 sends 4 beats. Source 1 chatters but must be ignored.
      rst = 1'b0; sel_req = 2'd2;
      step();
      chk("t1_busy", busy, 1);
      chk("t1_sel", active_sel, 2);
      chk("t1_rdy", in_ready, 4'b0100);
      chk("t1_ov0", out_valid, 0);
      for (int b = 1; b <= 4; b++) begin
         d2 = 16'h0101 * 16'(b);
         in_valid = 4'b0110;
         in_last  = (b == 4) ? 4'b0110 : 4'b0000;
         in_data  = {16'h0000, d2, 16'hBEEF, 16'h0000};
         step();
         chk("t1_ov", out_valid, 1);
         chk("t1_od", out_data, d2);
         chk("t1_ol", out_last, (b == 4) ? 1 : 0);
         chk("t1_pix", pix_cnt, (b == 4) ? 0 : b);
         $display("t1 beat %0d: data=%h last=%b pix=%0d", b, out_data, out_last, pix_cnt);
      end
      chk("t1_frm", frame_cnt, 1);
      chk("t1_busy_drop", busy, 0);
      chk("t1_rdy_idle", in_ready, 0);

      // Test 2: frame on source 1. A mid-frame request for 3 waits for the last beat.
      in_valid = '0; in_last = '0; sel_req = 2'd1;
      step();
      chk("t2_ov_drain", out_valid, 0);
      chk("t2_busy", busy, 1);
      chk("t2_sel1", active_sel, 1);
      chk("t2_rdy1", in_ready, 4'b0010);
      in_valid = 4'b0010; in_data = {16'h0, 16'h0, 16'h1111, 16'h0}; sel_req = 2'd3;
      step();
      chk("t2_sel_hold", active_sel, 1);
      chk("t2_od1", out_data, 16'h1111);
      chk("t2_rdy_hold", in_ready, 4'b0010);
      in_last = 4'b0010; in_data = {16'h0, 16'h0, 16'h2222, 16'h0};
      step();
      chk("t2_od2", out_data, 16'h2222);
      chk("t2_ol", out_last, 1);
      chk("t2_idle", busy, 0);
      chk("t2_frm", frame_cnt, 2);
      chk("t2_rdy_idle", in_ready, 0);
      in_valid = '0; in_last = '0;
      step();
      chk("t2_busy3", busy, 1);
      chk("t2_sel3", active_sel, 3);
      chk("t2_rdy3", in_ready, 4'b1000);
      chk("t2_ov_drain", out_valid, 0);
      $display("t2: switched to src %0d in_ready=%b", active_sel, in_ready);

      // Test 3: downstream stall for 3 cycles. No beat is lost or duplicated.
      in_valid = 4'b1000; in_data = {16'h3333, 48'h0};
      step();
      chk("t3_od_a", out_data, 16'h3333);
      chk("t3_pix_a", pix_cnt, 1);
      out_ready = 1'b0; in_data = {16'h4444, 48'h0};
      for (int s = 0; s < 3; s++) begin
         step();
         chk("t3_stall_rdy", in_ready, 0);
         chk("t3_stall_ov", out_valid, 1);
         chk("t3_stall_od", out_data, 16'h3333);
         chk("t3_stall_pix", pix_cnt, 1);
         $display("t3 stall %0d: out_data=%h in_ready=%b", s, out_data, in_ready);
      end
      out_ready = 1'b1;
      step();
      chk("t3_od_b", out_data, 16'h4444);
      chk("t3_pix_b", pix_cnt, 2);
      in_last = 4'b1000; in_data = {16'h5555, 48'h0};
      step();
      chk("t3_od_c", out_data, 16'h5555);
      chk("t3_ol", out_last, 1);
      chk("t3_frm", frame_cnt, 3);
      chk("t3_pix_c", pix_cnt, 0);
      in_valid = '0; in_last = '0; sel_req = 2'd0;
      step();
      chk("t3_busy0", busy, 1);
      chk("t3_sel0", active_sel, 0);
      chk("t3_ov0", out_valid, 0);

      // Test 4: reset after 2 of 4 beats aborts the frame.
      in_valid = 4'b0001; in_data = {48'h0, 16'h0A0A};
      step();
      in_data = {48'h0, 16'h0B0B};
      step();
      chk("t4_pix2", pix_cnt, 2);
      chk("t4_od", out_data, 16'h0B0B);
      in_data = {48'h0, 16'h0C0C}; rst = 1'b1;
      step();
      chk("t4_pix", pix_cnt, 0);
      chk("t4_frm", frame_cnt, 0);
      chk("t4_ov", out_valid, 0);
      chk("t4_od0", out_data, 0);
      chk("t4_rdy", in_ready, 0);
      chk("t4_busy", busy, 0);
      chk("t4_selerr3", sel_err3, 0);
      $display("t4: after reset pix=%0d out_valid=%b busy=%b", pix_cnt, out_valid, busy);

      // Illegal select on the 3-source instance: pulse and stay IDLE.
      rst = 1'b0; in_valid = '0;
      step();
      chk("t3b_selerr", sel_err3, 1);
      chk("t3b_idle", busy3, 0);
      chk("t3b_sel", active_sel3, 0);
      chk("t4_restart", busy, 1);
      sel_req3 = 2'd2;
      step();
      chk("t3b_selerr_clr", sel_err3, 0);
      chk("t3b_busy", busy3, 1);
      chk("t3b_sel2", active_sel3, 2);
      $display("sel_err3 check: busy3=%b active_sel3=%0d", busy3, active_sel3);

      // Test 5: short frame, exact frame, and a frame missing its last beat.
      exp_pix = 0;
      exp_frames = 0;
      send(0, 3, 1'b1, 3, 16'h1000, "t5a");
      send(0, 4, 1'b1, 0, 16'h2000, "t5b");
      send(0, 5, 1'b0, 4, 16'h3000, "t5c");
      chk("t5_pix_end", pix_cnt, 5);
      chk("t5_busy_end", busy, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
